// File: rtl/arm_mc_controller_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, datapath
// select codes, opcode classes and data-processing command helpers.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    EXECR,
    EXECI,
    ALUWB,
    BRANCH
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_WD   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_8  = 2'b00;
  localparam logic [1:0] IMM_12 = 2'b01;
  localparam logic [1:0] IMM_24 = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  function automatic logic dp_legal(input logic [3:0] cmd);
    return (cmd == CMD_AND) || (cmd == CMD_SUB) || (cmd == CMD_ADD) ||
           (cmd == CMD_TST) || (cmd == CMD_CMP) || (cmd == CMD_ORR);
  endfunction

  function automatic logic [1:0] dp_alu(input logic [3:0] cmd);
    logic [1:0] ctl;
    ctl = ALU_ADD;
    case (cmd)
      CMD_SUB, CMD_CMP: ctl = ALU_SUB;
      CMD_AND, CMD_TST: ctl = ALU_AND;
      CMD_ORR:          ctl = ALU_ORR;
      default:          ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

  // Compare/test only set flags and skip the writeback state
  function automatic logic dp_nowrite(input logic [3:0] cmd);
    return (cmd == CMD_CMP) || (cmd == CMD_TST);
  endfunction

  // Arithmetic ops own the carry and overflow flags
  function automatic logic dp_arith(input logic [3:0] cmd);
    return (cmd == CMD_ADD) || (cmd == CMD_SUB) || (cmd == CMD_CMP);
  endfunction

endpackage

// File: rtl/arm_mc_controller_condcheck.sv
// ARM condition-code evaluator: decides whether an instruction executes
// given its cond field and the stored {N,Z,C,V} flags.
module condcheck (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic w_n, w_z, w_c, w_v, w_ge;

  assign {w_n, w_z, w_c, w_v} = Flags;
  assign w_ge = (w_n == w_v);

  // Standard 16-entry condition table; 1111 never executes
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = w_z;
      4'b0001: CondEx = ~w_z;
      4'b0010: CondEx = w_c;
      4'b0011: CondEx = ~w_c;
      4'b0100: CondEx = w_n;
      4'b0101: CondEx = ~w_n;
      4'b0110: CondEx = w_v;
      4'b0111: CondEx = ~w_v;
      4'b1000: CondEx = w_c & ~w_z;
      4'b1001: CondEx = ~w_c | w_z;
      4'b1010: CondEx = w_ge;
      4'b1011: CondEx = ~w_ge;
      4'b1100: CondEx = ~w_z & w_ge;
      4'b1101: CondEx = w_z | ~w_ge;
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/arm_mc_controller.sv
// Moore control unit for the shared-memory multicycle ARM datapath.
module arm_mc_controller
  import arm_mc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUControl,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic        Illegal
);

  state_t     r_state, w_next;
  logic [3:0] r_flags;
  logic       r_condexr;

  logic       w_condex;
  logic [3:0] w_cond, w_cmd, w_rd;
  logic [1:0] w_op;
  logic [5:0] w_funct;
  logic       w_s, w_rd15, w_flag_upd;
  logic       w_pcwrite, w_memwrite, w_regwrite, w_irwrite;
  logic       w_unused;

  assign w_cond   = Instr[19:16];
  assign w_op     = Instr[15:14];
  assign w_funct  = Instr[13:8];
  assign w_rd     = Instr[3:0];
  assign w_cmd    = w_funct[4:1];
  assign w_s      = w_funct[0];
  assign w_rd15   = (w_rd == 4'hF);
  assign w_unused = ^Instr[7:4];

  condcheck u_condcheck (
    .Cond   (w_cond),
    .Flags  (r_flags),
    .CondEx (w_condex)
  );

  assign w_flag_upd = ((r_state == EXECR) || (r_state == EXECI)) && w_s && r_condexr;

  // State register, flags register and condition latched in DECODE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_flags   <= '0;
      r_condexr <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE)
        r_condexr <= w_condex;
      if (w_flag_upd) begin
        r_flags[3:2] <= ALUFlags[3:2];
        if (dp_arith(w_cmd))
          r_flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    w_next     = FETCH;
    w_pcwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    w_irwrite  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUControl = ALU_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_WD;
    ImmSrc     = IMM_8;
    RegSrc     = 2'b00;
    Illegal    = 1'b0;
    case (r_state)
      FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        w_next    = DECODE;
      end
      DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        case (w_op)
          OP_MEM: w_next = MEMADR;
          OP_BR:  w_next = BRANCH;
          OP_DP: begin
            if (!dp_legal(w_cmd)) begin
              Illegal = 1'b1;
              w_next  = FETCH;
            end else begin
              w_next = w_funct[5] ? EXECI : EXECR;
            end
          end
          default: begin
            Illegal = 1'b1;
            w_next  = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcB = SRCB_IMM;
        ImmSrc  = IMM_12;
        w_next  = w_funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc = 1'b1;
        w_next = MEMWB;
      end
      MEMWR: begin
        AdrSrc     = 1'b1;
        w_memwrite = r_condexr;
        RegSrc     = 2'b10;
      end
      EXECR, EXECI: begin
        ALUControl = dp_alu(w_cmd);
        if (r_state == EXECI) begin
          ALUSrcB = SRCB_IMM;
          ImmSrc  = IMM_8;
        end
        w_next = dp_nowrite(w_cmd) ? FETCH : ALUWB;
      end
      MEMWB, ALUWB: begin
        ResultSrc = (r_state == MEMWB) ? RES_DATA : RES_ALUOUT;
        // A write to R15 redirects the PC instead of the register file
        if (w_rd15) w_pcwrite  = r_condexr;
        else        w_regwrite = r_condexr;
      end
      BRANCH: begin
        RegSrc    = 2'b01;
        ALUSrcB   = SRCB_IMM;
        ImmSrc    = IMM_24;
        ResultSrc = RES_ALURESULT;
        w_pcwrite = r_condexr;
      end
      default: w_next = FETCH;
    endcase
  end

  // Architectural enables are held off for as long as reset is asserted
  assign PCWrite  = w_pcwrite  & ~reset;
  assign MemWrite = w_memwrite & ~reset;
  assign RegWrite = w_regwrite & ~reset;
  assign IRWrite  = w_irwrite  & ~reset;

endmodule
